// File: rtl/nmr_acq_window.sv
// NMR acquisition window: follows the pulse sequencer's sync/pulse/blank
// outputs, waits a programmable dead time after the last pulse/blank, then
// streams AcqLen decimated ADC samples with tlast on the final beat.
module nmr_acq_window #(
    parameter int unsigned US_DIVIDER = 125,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  sync_in,
    input  logic                  pulse_in,
    input  logic                  blank_in,
    input  logic [31:0]           DeadTime_in,
    input  logic [31:0]           AcqLen_in,
    input  logic [15:0]           Decim_in,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  adc_valid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  acq_active,
    output logic                  overflow
);

    localparam logic [31:0] PreMax = 32'(US_DIVIDER - 1);

    typedef enum logic [2:0] {
        StIdle, StWaitSync, StWaitPulse, StDead, StAcq, StFlush
    } state_e;

    state_e                state_q, state_d;
    logic                  sync_q, arm_q;
    logic [31:0]           dead_time_q, dead_time_d;
    logic [31:0]           acq_len_q, acq_len_d;
    logic [15:0]           decim_q, decim_d;
    logic [31:0]           pre_q, pre_d;      // cycles within the current microsecond
    logic [31:0]           ticks_q, ticks_d;  // whole microseconds of dead time elapsed
    logic [15:0]           dec_cnt_q, dec_cnt_d;
    logic [31:0]           kept_q, kept_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  overflow_q, overflow_d;

    logic sync_rise, handshake, dead_done;

    assign sync_rise = sync_in & ~sync_q;
    assign handshake = tvalid_q & m_tready;
    // Counting in us ticks avoids forming the DeadTime*US_DIVIDER product.
    // Next state is ACQ when the cycle just ending is cycle DeadTime*US_DIVIDER-1.
    assign dead_done = (dead_time_q == 32'd0) ||
                       ((pre_q == PreMax) && (ticks_q == dead_time_q - 32'd1));

    // State, counters and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            sync_q      <= 1'b0;
            arm_q       <= 1'b0;
            dead_time_q <= '0;
            acq_len_q   <= '0;
            decim_q     <= 16'd1;
            pre_q       <= '0;
            ticks_q     <= '0;
            dec_cnt_q   <= '0;
            kept_q      <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_in;
            arm_q       <= arm;
            dead_time_q <= dead_time_d;
            acq_len_q   <= acq_len_d;
            decim_q     <= decim_d;
            pre_q       <= pre_d;
            ticks_q     <= ticks_d;
            dec_cnt_q   <= dec_cnt_d;
            kept_q      <= kept_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state, dead-time counting, decimation and output-beat management.
    always_comb begin
        state_d     = state_q;
        dead_time_d = dead_time_q;
        acq_len_d   = acq_len_q;
        decim_d     = decim_q;
        pre_d       = pre_q;
        ticks_d     = ticks_q;
        dec_cnt_d   = dec_cnt_q;
        kept_d      = kept_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        overflow_d  = overflow_q;

        if (handshake) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d = StWaitSync;
                    if (!arm_q) overflow_d = 1'b0;
                end
            end
            StWaitSync: begin
                if (!arm) begin
                    state_d = StIdle;
                end else if (sync_rise) begin
                    dead_time_d = DeadTime_in;
                    acq_len_d   = AcqLen_in;
                    decim_d     = (Decim_in == 16'd0) ? 16'd1 : Decim_in;
                    state_d     = StWaitPulse;
                end
            end
            StWaitPulse: begin
                // Disarming here also abandons the shot rather than waiting forever.
                if (!arm) begin
                    state_d = StIdle;
                end else if (pulse_in) begin
                    pre_d   = '0;
                    ticks_d = '0;
                    state_d = StDead;
                end
            end
            StDead: begin
                if (!arm) begin
                    state_d = StIdle;
                end else if (pulse_in || blank_in) begin
                    pre_d   = '0;
                    ticks_d = '0;
                end else if (dead_done) begin
                    dec_cnt_d = '0;
                    kept_d    = '0;
                    state_d   = (acq_len_q == 32'd0) ? StWaitSync : StAcq;
                end else if (pre_q == PreMax) begin
                    pre_d   = '0;
                    ticks_d = ticks_q + 32'd1;
                end else begin
                    pre_d = pre_q + 32'd1;
                end
            end
            StAcq: begin
                if (adc_valid) begin
                    dec_cnt_d = (dec_cnt_q == decim_q - 16'd1) ? 16'd0 : dec_cnt_q + 16'd1;
                    if (dec_cnt_q == 16'd0) begin
                        if (tvalid_q && !m_tready) begin
                            // Dropped and not counted, so the shot length is preserved.
                            overflow_d = 1'b1;
                        end else begin
                            tdata_d  = adc_data;
                            tvalid_d = 1'b1;
                            tlast_d  = (kept_q + 32'd1 == acq_len_q);
                            kept_d   = kept_q + 32'd1;
                            if (kept_q + 32'd1 == acq_len_q) state_d = StFlush;
                        end
                    end
                end
            end
            StFlush: begin
                if (handshake && tlast_q) state_d = arm ? StWaitSync : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign m_tdata    = tdata_q;
    assign m_tvalid   = tvalid_q;
    assign m_tlast    = tlast_q;
    assign overflow   = overflow_q;
    assign acq_active = (state_q == StAcq) || (state_q == StFlush);

endmodule

// File: tb/tb_nmr_acq_window.sv
// Directed bench for nmr_acq_window with US_DIVIDER=5.
module tb_nmr_acq_window;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arm = 1'b0;
    logic        sync_in = 1'b0;
    logic        pulse_in = 1'b0;
    logic        blank_in = 1'b0;
    logic [31:0] DeadTime_in = '0;
    logic [31:0] AcqLen_in = '0;
    logic [15:0] Decim_in = '0;
    logic [15:0] adc_data = '0;
    logic        adc_valid = 1'b1;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic        acq_active;
    logic        overflow;

    int total = 0;
    int bad = 0;
    int cyc = 0;       // posedges seen so far
    int base = 0;      // cycle at which the ramp reads 0 (expected ACQ entry)
    int low_cyc = 0;   // cycle 0 of dead time
    bit act_seen = 1'b0;
    logic [15:0] q_data[$];
    logic        q_last[$];
    int          exp_q[$];

    nmr_acq_window #(
        .US_DIVIDER(5),
        .DATA_WIDTH(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .sync_in    (sync_in),
        .pulse_in   (pulse_in),
        .blank_in   (blank_in),
        .DeadTime_in(DeadTime_in),
        .AcqLen_in  (AcqLen_in),
        .Decim_in   (Decim_in),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .acq_active (acq_active),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC ramp: value seen at posedge n is n - base.
    always @(negedge clk) adc_data = 16'(cyc - base);

    // Beat monitor, sampled mid-low-phase after the stimulus has settled.
    always @(negedge clk) begin
        #2;
        if (m_tvalid && m_tready) begin
            q_data.push_back(m_tdata);
            q_last.push_back(m_tlast);
        end
        if (acq_active) act_seen = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Arms a shot: sync edge, one pulse of hi cycles, blank trailing by one cycle.
    task automatic start_shot(input int dt, input int len, input int dec, input int hi);
        DeadTime_in = dt;
        AcqLen_in   = len;
        Decim_in    = 16'(dec);
        sync_in = 1'b1; tick(1);
        sync_in = 1'b0; tick(1);
        pulse_in = 1'b1; blank_in = 1'b1; tick(hi);
        pulse_in = 1'b0; tick(1);
        blank_in = 1'b0;
        low_cyc  = cyc;
        base     = (dt == 0) ? low_cyc + 1 : low_cyc + dt * 5;
        q_data.delete();
        q_last.delete();
        act_seen = 1'b0;
    endtask

    task automatic wait_beats(input int budget);
        int k = 0;
        while (q_data.size() < exp_q.size() && k < budget) begin
            tick(1);
            k++;
        end
        tick(3);
    endtask

    task automatic check_beats(input string tag);
        check({tag, "_count"}, q_data.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < q_data.size()) begin
                check($sformatf("%s_data%0d", tag, i), q_data[i], exp_q[i]);
                check($sformatf("%s_last%0d", tag, i), q_last[i], i == exp_q.size() - 1);
            end
        end
    endtask

    initial begin
        // Reset
        tick(3);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_active", acq_active, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b1;
        arm = 1'b1;
        tick(2);

        // Sync without any pulse never opens a window
        q_data.delete();
        act_seen = 1'b0;
        sync_in = 1'b1; tick(1);
        sync_in = 1'b0; tick(30);
        check("nopulse_active", act_seen, 0);
        check("nopulse_beats", q_data.size(), 0);
        arm = 1'b0; tick(2);
        arm = 1'b1; tick(2);

        // Basic shot: ACQ 20 cycles after cycle 0
        start_shot(4, 8, 1, 3);
        tick(19);
        check("basic_early", acq_active, 0);
        tick(1);
        check("basic_entry", acq_active, 1);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(i);
        wait_beats(60);
        check_beats("basic");
        check("basic_done", acq_active, 0);

        // Second pulse restarts the dead time
        start_shot(4, 2, 1, 2);
        tick(8);
        check("multi_mid", acq_active, 0);
        pulse_in = 1'b1; blank_in = 1'b1; tick(2);
        pulse_in = 1'b0; tick(1);
        blank_in = 1'b0;
        low_cyc = cyc;
        base = low_cyc + 20;
        tick(19);
        check("multi_early", acq_active, 0);
        tick(1);
        check("multi_entry", acq_active, 1);
        exp_q = '{0, 1};
        wait_beats(30);
        check_beats("multi");

        // Decimation by 3
        start_shot(0, 4, 3, 2);
        exp_q = '{0, 3, 6, 9};
        wait_beats(40);
        check_beats("dec3");

        // Decim=0 behaves as 1
        start_shot(2, 3, 0, 2);
        exp_q = '{0, 1, 2};
        wait_beats(40);
        check_beats("dec0");

        // Backpressure: ready low for posedges base+2..base+7
        start_shot(1, 6, 1, 2);
        tick(7);
        m_tready = 1'b0; tick(6);
        m_tready = 1'b1;
        exp_q = '{0, 1, 8, 9, 10, 11};
        wait_beats(40);
        check_beats("bp");
        check("bp_overflow", overflow, 1);
        arm = 1'b0; tick(2);
        check("bp_ovf_hold", overflow, 1);
        arm = 1'b1; tick(2);
        check("bp_ovf_clear", overflow, 0);

        // Asynchronous reset in ACQ
        start_shot(0, 8, 1, 2);
        tick(3);
        check("abort_pre_tvalid", m_tvalid, 1);
        #3 rst = 1'b0;
        #1;
        check("abort_tvalid", m_tvalid, 0);
        check("abort_active", acq_active, 0);
        @(negedge clk) rst = 1'b1;
        tick(2);

        // Disarm during dead time
        start_shot(2, 4, 1, 2);
        tick(3);
        arm = 1'b0; tick(30);
        check("disarm_beats", q_data.size(), 0);
        check("disarm_active", act_seen, 0);
        arm = 1'b1; tick(2);

        // AcqLen=0: no window, back in WAIT_SYNC for the next shot
        start_shot(1, 0, 1, 2);
        tick(30);
        check("len0_beats", q_data.size(), 0);
        check("len0_active", act_seen, 0);
        start_shot(0, 2, 1, 2);
        exp_q = '{0, 1};
        wait_beats(30);
        check_beats("after_len0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
